ro_freq_meter_ctrl: RTL and testbench
=====================================

Name: ro_freq_meter_ctrl

Overview:
- Controller for the ring oscillator: drives its `en` input, waits a settle interval, then counts oscillator rising edges over a programmable window of system-clock cycles.
- Reports the edge count with a one-cycle `done` pulse.
- Sits between the lab top-level control logic and the ring oscillator instance. It is the only driver of the oscillator enable.
- The oscillator output is asynchronous to `clk` and is synchronised internally.

Parameters:
- WINDOW_W, 16, width of `window_len` (measurement window in `clk` cycles).
- CNT_W, 16, width of the edge counter and `count` output.
- SETTLE_CYCLES, 8, `clk` cycles with `ro_en` high before counting starts; must be >= SYNC_STAGES+1.
- SYNC_STAGES, 2, flops in the `ro_clk` synchroniser; minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- abort  input  1  cancel any in-progress measurement.
- window_len  input  WINDOW_W  window length in `clk` cycles; latched on accepted start.
- ro_clk  input  1  ring oscillator output; asynchronous.
- ro_en  output  1  ring oscillator enable.
- busy  output  1  high in SETTLE, MEASURE and DONE.
- done  output  1  one-cycle pulse when a new result is valid.
- count  output  CNT_W  last completed result; holds its value between measurements.
- overflow  output  1  last result saturated; updated together with `count`.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; ro_en=0, busy=0, done=0, count=0, overflow=0.
  - Synchroniser and edge counter cleared.
  - Reset mid-measurement behaves identically: the oscillator is disabled on the next edge.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE, start=1, abort=0, window_len!=0:
  - latch window_len; go to SETTLE.
  - ro_en=1 and busy=1 from the next cycle.
- IDLE, start=1, window_len==0:
  - go to DONE directly; ro_en never asserted.
  - result count=0, overflow=0.
- SETTLE:
  - lasts exactly SETTLE_CYCLES cycles; edge counter held at 0.
  - The synchroniser runs so the pipeline is flushed of pre-enable values.
  - Then go to MEASURE.
- MEASURE:
  - lasts exactly the latched window_len cycles.
  - Each cycle, a synchronised rising edge (sync_q=1, prev=0) increments the counter.
  - At all-ones the counter saturates and sets an internal overflow flag.
  - Edges still inside the synchroniser when the window closes are not counted.
- DONE:
  - single cycle; count and overflow loaded from the counter and flag.
  - done=1 for this cycle only; ro_en=0; busy=1.
  - Next state is IDLE.
- Timing, with start accepted at cycle 0 (S=SETTLE_CYCLES, W=window_len):
  - ro_en rises at cycle 1.
  - Counting covers cycles S+1..S+W.
  - done and ro_en=0 at cycle S+W+1.
  - busy=0 at cycle S+W+2.
- abort=1 in any non-IDLE state:
  - next cycle state=IDLE, ro_en=0, busy=0.
  - No done pulse; count and overflow keep their previous values.
- abort and start both high in IDLE: abort wins and the block stays IDLE.
- abort in the DONE cycle: ignored; the result is already committed.
- start while busy: ignored; it is not queued.
- The ro_clk frequency must be below clk/2 for exact counting; above that, counts are under-reported (no error flag).

Optional Feature:
- Macro: RO_CONT_MEAS_EN.
- Defined:
  - adds input `cont` (1 bit).
  - If cont=1 in the DONE cycle, the next state is MEASURE instead of IDLE, with the counter and flag cleared and ro_en held high (no re-settle).
  - This repeats back-to-back windows, with a done pulse every W+1 cycles.
  - cont=0, or abort, returns the block to IDLE as normal.
- Not defined: no `cont` port; strictly single-shot.

Decomposition:
- Package ro_ctrl_pkg:
  - state typedef (IDLE/SETTLE/MEASURE/DONE).
  - default constants for SETTLE_CYCLES and SYNC_STAGES.
- Sub-module ro_edge_sync:
  - SYNC_STAGES flop chain plus previous-value flop.
  - outputs a one-cycle `rise` pulse.
  - clear input driven by rst or the IDLE state.

Test Plan:
- Plain measurement:
  - stimulus: clk 10 ns, ro_clk modelled at 50 ns period (3 stages x 8330 ps), window_len=1000, start pulse.
  - required: ro_en high at cycle 1; done at cycle 1009; count=200±1; overflow=0; busy low the following cycle.
- Saturation:
  - stimulus: CNT_W=8, window_len=2000, same ro_clk.
  - required: count=255, overflow=1.
- Abort:
  - stimulus: abort at cycle 300 of MEASURE, after a prior result count=200.
  - required: ro_en=0 and busy=0 next cycle; no done pulse; count stays 200.
- Zero window and ignored start:
  - stimulus: window_len=0 with start.
  - required: done at cycle 1, count=0, ro_en never high.
  - stimulus: a second start while busy.
  - required: no extra measurement.
- Reset mid-run:
  - stimulus: rst=1 during SETTLE.
  - required: all outputs 0 on the next edge; a following start measures normally.
- Continuous mode (RO_CONT_MEAS_EN):
  - stimulus: cont=1, window_len=100.
  - required: done pulses every 101 cycles with count=20±1, ro_en continuously high.
  - stimulus: drop cont.
  - required: return to IDLE after the current window.

Source files
------------

// File: rtl/ro_ctrl_pkg.sv
// Shared state encoding and default constants for the ring-oscillator frequency meter.
// Imported by ro_edge_sync and ro_freq_meter_ctrl.
package ro_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ro_state_e;

    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SYNC_STAGES   = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronises the free-running oscillator output into the clk domain and flags
// each rising edge with a one-cycle pulse; clear flushes the chain to zero.
module ro_edge_sync
    import ro_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic clear,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
        if (clear) begin
            sync_d = '0;
            prev_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        sync_q <= sync_d;
        prev_q <= prev_d;
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter_ctrl.sv
// Ring-oscillator frequency meter: enable, settle, count synchronised edges over a window.
// Optional back-to-back windows via the `cont` input when RO_CONT_MEAS_EN is defined.
module ro_freq_meter_ctrl
    import ro_ctrl_pkg::*;
#(
    parameter int WINDOW_W      = 16,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic                ro_clk,
`ifdef RO_CONT_MEAS_EN
    input  logic                cont,
`endif
    output logic                ro_en,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic                overflow
);

    // One down-counter times both the settle interval and the window.
    localparam int TMR_W = max_int(WINDOW_W, $clog2(SETTLE_CYCLES + 1));
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    ro_state_e           state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [WINDOW_W-1:0] window_q, window_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                ro_en_q, ro_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;

    logic                sync_clear;
    logic                rise;
    logic [CNT_W-1:0]    cnt_step;
    logic                ovf_step;

    assign sync_clear = rst || (state_q == IDLE);

    ro_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .clear    (sync_clear),
        .async_in (ro_clk),
        .rise     (rise)
    );

    // Saturating edge counter value including this cycle's edge.
    always_comb begin
        cnt_step = cnt_q;
        ovf_step = ovf_q;
        if (rise) begin
            if (&cnt_q) begin
                ovf_step = 1'b1;
            end else begin
                cnt_step = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        window_d   = window_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        ro_en_d    = ro_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (start && !abort) begin
                    busy_d = 1'b1;
                    if (window_len == '0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d  = SETTLE;
                        window_d = window_len;
                        timer_d  = SETTLE_LOAD;
                        ro_en_d  = 1'b1;
                    end
                end
            end

            SETTLE: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                    ro_en_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (timer_q == '0) begin
                    state_d = MEASURE;
                    timer_d = TMR_W'(window_q) - TMR_W'(1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                    ro_en_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cnt_step;
                    ovf_d = ovf_step;
                    if (timer_q == '0) begin
                        // The last window cycle's edge is folded straight into the result.
                        state_d    = DONE;
                        done_d     = 1'b1;
                        count_d    = cnt_step;
                        overflow_d = ovf_step;
`ifdef RO_CONT_MEAS_EN
                        ro_en_d    = cont;
`else
                        ro_en_d    = 1'b0;
`endif
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                ro_en_d = 1'b0;
                busy_d  = 1'b0;
`ifdef RO_CONT_MEAS_EN
                if (cont && !abort) begin
                    state_d = MEASURE;
                    timer_d = TMR_W'(window_q) - TMR_W'(1);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    ro_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
                ro_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            window_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ro_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            window_q   <= window_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ro_en_q    <= ro_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign ro_en    = ro_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter_ctrl.sv
// Bench for ro_freq_meter_ctrl: gated ring-oscillator model with random periods/windows,
// expected counts from window duration divided by oscillator period.
`timescale 1ns/1ps
module tb_ro_freq_meter_ctrl;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] window_len;
    logic        ro_clk = 1'b0;
`ifdef RO_CONT_MEAS_EN
    logic        cont;
`endif

    logic        ro_en, busy, done, overflow;
    logic [15:0] count;
    logic        sat_ro_en, sat_busy, sat_done, sat_overflow;
    logic [7:0]  sat_count;

    int          n_cmp = 0;
    int          n_err = 0;
    realtime     half_ns = 24.99;

    ro_freq_meter_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .window_len (window_len),
        .ro_clk     (ro_clk),
`ifdef RO_CONT_MEAS_EN
        .cont       (cont),
`endif
        .ro_en      (ro_en),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .overflow   (overflow)
    );

    ro_freq_meter_ctrl #(.CNT_W(8)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .window_len (window_len),
        .ro_clk     (ro_clk),
`ifdef RO_CONT_MEAS_EN
        .cont       (cont),
`endif
        .ro_en      (sat_ro_en),
        .busy       (sat_busy),
        .done       (sat_done),
        .count      (sat_count),
        .overflow   (sat_overflow)
    );

    always #5 clk = ~clk;

    // Oscillator runs only while enabled, idling low otherwise.
    always begin
        if (ro_en === 1'b1) begin
            #(half_ns);
            ro_clk = ~ro_clk;
        end else begin
            ro_clk = 1'b0;
            @(posedge ro_en);
        end
    end

    function automatic real exp_count(input int win, input real half);
        return (win * 10.0) / (2.0 * half);
    endfunction

    function automatic bit near(input logic [15:0] got, input real expc);
        real diff;
        diff = real'(got) - expc;
        return (diff <= 1.0) && (diff >= -1.0);
    endfunction

    task automatic step(inout int cyc);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_meas(input logic [15:0] win, output int cyc);
        @(negedge clk);
        start      = 1'b1;
        window_len = win;
        @(negedge clk);
        start      = 1'b0;
        window_len = 16'($urandom);
        cyc        = 1;
    endtask

    task automatic wait_done(input int budget, inout int cyc, output int gaps);
        gaps = 0;
        while (done !== 1'b1 && budget > 0) begin
            if (ro_en !== 1'b1) gaps++;
            @(negedge clk);
            cyc++;
            budget--;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ro_en, busy, done, overflow} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000", {ro_en, busy, done, overflow});
        end
        n_cmp++;
        if (count !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_count: got %0d, expected 0", count);
        end
        n_cmp++;
        if ({sat_ro_en, sat_busy, sat_done, sat_overflow, sat_count} !== 12'd0) begin
            n_err++;
            $display("[TB] FAIL reset_sat: got %0h, expected 0", {sat_ro_en, sat_busy, sat_done, sat_overflow, sat_count});
        end
        rst = 1'b0;
    endtask

    task automatic test_plain();
        int  cyc, gaps, win;
        real expc;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                half_ns = 24.99;
                win     = 1000;
            end else begin
                half_ns = $urandom_range(12000, 40000) / 1000.0;
                win     = $urandom_range(40, 800);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            expc = exp_count(win, half_ns);
            start_meas(16'(win), cyc);
            n_cmp++;
            if (ro_en !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL plain_ro_en_c1: got %b, expected 1", ro_en);
            end
            wait_done(win + S + 50, cyc, gaps);
            n_cmp++;
            if (cyc != win + S + 1) begin
                n_err++;
                $display("[TB] FAIL plain_done_cycle: got %0d, expected %0d", cyc, win + S + 1);
            end
            n_cmp++;
            if (gaps != 0) begin
                n_err++;
                $display("[TB] FAIL plain_ro_en_gaps: got %0d, expected 0", gaps);
            end
            n_cmp++;
            if (!near(count, expc)) begin
                n_err++;
                $display("[TB] FAIL plain_count: got %0d, expected %0.2f +-1", count, expc);
            end
            n_cmp++;
            if ({overflow, ro_en, busy} !== 3'b001) begin
                n_err++;
                $display("[TB] FAIL plain_done_flags: got %b, expected 001", {overflow, ro_en, busy});
            end
            @(negedge clk);
            n_cmp++;
            if ({busy, done, ro_en} !== 3'b000) begin
                n_err++;
                $display("[TB] FAIL plain_after_done: got %b, expected 000", {busy, done, ro_en});
            end
        end
    endtask

    task automatic test_saturation();
        int  cyc, gaps;
        real expc;
        half_ns = 24.99;
        expc    = exp_count(2000, half_ns);
        start_meas(16'd2000, cyc);
        wait_done(2100, cyc, gaps);
        n_cmp++;
        if (cyc != 2000 + S + 1) begin
            n_err++;
            $display("[TB] FAIL sat_done_cycle: got %0d, expected %0d", cyc, 2000 + S + 1);
        end
        n_cmp++;
        if (!near(count, expc) || overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL sat_wide_count: got %0d ovf %b, expected %0.2f +-1 ovf 0", count, overflow, expc);
        end
        n_cmp++;
        if (sat_done !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL sat_narrow_done: got %b, expected 1", sat_done);
        end
        n_cmp++;
        if (sat_count !== 8'd255 || sat_overflow !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL sat_narrow_count: got %0d ovf %b, expected 255 ovf 1", sat_count, sat_overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int  cyc, gaps, pulses;
        real expc;
        half_ns = 24.99;
        expc    = exp_count(1000, half_ns);
        start_meas(16'd1000, cyc);
        wait_done(1100, cyc, gaps);
        n_cmp++;
        if (!near(count, expc)) begin
            n_err++;
            $display("[TB] FAIL abort_prior_count: got %0d, expected %0.2f +-1", count, expc);
        end
        @(negedge clk);
        start_meas(16'd1000, cyc);
        while (cyc < S + 300) step(cyc);
        abort = 1'b1;
        step(cyc);
        abort = 1'b0;
        n_cmp++;
        if ({ro_en, busy, done} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL abort_measure_next: got %b, expected 000", {ro_en, busy, done});
        end
        pulses = 0;
        repeat (1100) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            step(cyc);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles, expected 0", pulses);
        end
        n_cmp++;
        if (!near(count, expc) || overflow !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_count_held: got %0d ovf %b, expected %0.2f +-1 ovf 0", count, overflow, expc);
        end
        start_meas(16'd1000, cyc);
        while (cyc < 3) step(cyc);
        abort = 1'b1;
        step(cyc);
        abort = 1'b0;
        n_cmp++;
        if ({ro_en, busy} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL abort_settle_next: got %b, expected 00", {ro_en, busy});
        end
        @(negedge clk);
        abort = 1'b1; start = 1'b1; window_len = 16'd50;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (80) begin
            if (done === 1'b1 || busy === 1'b1 || ro_en === 1'b1) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("[TB] FAIL abort_start_idle: got %0d active cycles, expected 0", pulses);
        end
        expc = exp_count(60, half_ns);
        start_meas(16'd60, cyc);
        wait_done(200, cyc, gaps);
        abort = 1'b1;
        step(cyc);
        abort = 1'b0;
        n_cmp++;
        if (!near(count, expc) || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_in_done: got %0d busy %b, expected %0.2f +-1 busy 0", count, busy, expc);
        end
    endtask

    task automatic test_zero_window();
        int cyc, en_seen;
        start_meas(16'd0, cyc);
        n_cmp++;
        if ({done, busy, ro_en, overflow} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL zero_done_c1: got %b, expected 1100", {done, busy, ro_en, overflow});
        end
        n_cmp++;
        if (count !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL zero_count: got %0d, expected 0", count);
        end
        step(cyc);
        n_cmp++;
        if ({done, busy, ro_en} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL zero_after: got %b, expected 000", {done, busy, ro_en});
        end
        en_seen = 0;
        repeat (10) begin
            if (ro_en !== 1'b0 || done !== 1'b0) en_seen++;
            step(cyc);
        end
        n_cmp++;
        if (en_seen != 0) begin
            n_err++;
            $display("[TB] FAIL zero_ro_en_quiet: got %0d, expected 0", en_seen);
        end
    endtask

    task automatic test_ignored_start();
        int  cyc, gaps, pulses;
        real expc;
        half_ns = 24.99;
        expc    = exp_count(100, half_ns);
        start_meas(16'd100, cyc);
        while (cyc < 50) step(cyc);
        start = 1'b1; window_len = 16'd5;
        step(cyc);
        start = 1'b0;
        wait_done(200, cyc, gaps);
        n_cmp++;
        if (cyc != 100 + S + 1) begin
            n_err++;
            $display("[TB] FAIL busy_start_done_cycle: got %0d, expected %0d", cyc, 100 + S + 1);
        end
        n_cmp++;
        if (!near(count, expc)) begin
            n_err++;
            $display("[TB] FAIL busy_start_count: got %0d, expected %0.2f +-1", count, expc);
        end
        step(cyc);
        pulses = 0;
        repeat (200) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            step(cyc);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("[TB] FAIL busy_start_not_queued: got %0d active cycles, expected 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int  cyc, gaps, win;
        real expc;
        start_meas(16'd100, cyc);
        while (cyc < 4) step(cyc);
        rst = 1'b1;
        step(cyc);
        n_cmp++;
        if ({ro_en, busy, done, overflow} !== 4'b0000 || count !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_outputs: got %b count %0d, expected 0000 count 0",
                     {ro_en, busy, done, overflow}, count);
        end
        rst     = 1'b0;
        half_ns = $urandom_range(12000, 40000) / 1000.0;
        win     = $urandom_range(100, 300);
        expc    = exp_count(win, half_ns);
        start_meas(16'(win), cyc);
        wait_done(win + S + 50, cyc, gaps);
        n_cmp++;
        if (cyc != win + S + 1 || !near(count, expc)) begin
            n_err++;
            $display("[TB] FAIL reset_mid_rerun: got cycle %0d count %0d, expected cycle %0d count %0.2f +-1",
                     cyc, count, win + S + 1, expc);
        end
        @(negedge clk);
    endtask

`ifdef RO_CONT_MEAS_EN
    task automatic test_continuous();
        int  cyc, gaps, prev;
        real expc;
        half_ns = 24.99;
        expc    = exp_count(100, half_ns);
        cont    = 1'b1;
        start_meas(16'd100, cyc);
        wait_done(200, cyc, gaps);
        n_cmp++;
        if (cyc != 100 + S + 1 || !near(count, expc) || ro_en !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cont_first: got cycle %0d count %0d ro_en %b, expected %0d %0.2f 1",
                     cyc, count, ro_en, 100 + S + 1, expc);
        end
        prev = cyc;
        for (int k = 0; k < 2; k++) begin
            step(cyc);
            if (k == 1) cont = 1'b0;
            wait_done(200, cyc, gaps);
            n_cmp++;
            if (cyc != prev + 101 || gaps != 0 || !near(count, expc)) begin
                n_err++;
                $display("[TB] FAIL cont_window: got cycle %0d gaps %0d count %0d, expected %0d 0 %0.2f",
                         cyc, gaps, count, prev + 101, expc);
            end
            prev = cyc;
        end
        step(cyc);
        n_cmp++;
        if ({busy, ro_en, done} !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL cont_stop: got %b, expected 000", {busy, ro_en, done});
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        window_len = 16'd0;
`ifdef RO_CONT_MEAS_EN
        cont       = 1'b0;
`endif
        test_reset();
        test_plain();
        test_saturation();
        test_abort();
        test_zero_window();
        test_ignored_start();
        test_reset_mid();
`ifdef RO_CONT_MEAS_EN
        test_continuous();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
